// File: rtl/crosswalk_controller_pkg.sv
// Shared encodings for the crosswalk controller and the downstream display/light blocks.
// Phase state codes, the countdown-digit threshold and the lamp decode used by the top.
package crosswalk_controller_pkg;

  localparam logic [2:0] ST_GREEN    = 3'd0;
  localparam logic [2:0] ST_YELLOW   = 3'd1;
  localparam logic [2:0] ST_RED_PRE  = 3'd2;
  localparam logic [2:0] ST_WALK     = 3'd3;
  localparam logic [2:0] ST_RED_POST = 3'd4;

  // The pedestrian display shows countdown digits only once master_timer drops to this value.
  localparam logic [6:0] COUNTDOWN_SHOW = 7'd30;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
    logic ped;
  } lamps_t;

  function automatic lamps_t lamp_decode(input logic [2:0] st);
    lamps_t l;
    l = '{green: 1'b0, yellow: 1'b0, red: 1'b1, ped: 1'b0};
    case (st)
      ST_GREEN:  l = '{green: 1'b1, yellow: 1'b0, red: 1'b0, ped: 1'b0};
      ST_YELLOW: l = '{green: 1'b0, yellow: 1'b1, red: 1'b0, ped: 1'b0};
      ST_WALK:   l = '{green: 1'b0, yellow: 1'b0, red: 1'b1, ped: 1'b1};
      default:   l = '{green: 1'b0, yellow: 1'b0, red: 1'b1, ped: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/crosswalk_controller_button_sync.sv
// Two-flop synchroniser for a raw asynchronous input followed by a one-clk rising-edge pulse.
// Reusable for any push-button style input.
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= async_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/crosswalk_controller.sv
// Signalised crosswalk sequencer: vehicle green/yellow/red, pedestrian walk phase,
// latched push-button request and a per-phase seconds countdown advanced by tick_1hz.
module crosswalk_controller
  import crosswalk_controller_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = 20,
  parameter int unsigned YELLOW_TIME = 4,
  parameter int unsigned CLEAR_TIME  = 2,
  parameter int unsigned WALK_TIME   = 35
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       ped_button,
  output logic [6:0] master_timer,
  output logic       ped_enable,
  output logic       car_green,
  output logic       car_yellow,
  output logic       car_red,
  output logic       req_pending,
  output logic [2:0] fsm_state
);

  localparam logic [6:0] GREEN_LEN  = 7'(MIN_GREEN);
  localparam logic [6:0] YELLOW_LEN = 7'(YELLOW_TIME);
  localparam logic [6:0] CLEAR_LEN  = 7'(CLEAR_TIME);
  localparam logic [6:0] WALK_LEN   = 7'(WALK_TIME);

  logic [2:0] state_q;
  logic [2:0] next_state;
  logic [6:0] timer_d;
  logic       req_d;
  logic       btn_rise;
  logic       enter_walk;
  lamps_t     lamps_d;

  button_sync_edge u_button_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ped_button),
    .rise     (btn_rise)
  );

  function automatic logic [6:0] phase_len(input logic [2:0] st);
    case (st)
      ST_YELLOW:   return YELLOW_LEN;
      ST_RED_PRE:  return CLEAR_LEN;
      ST_WALK:     return WALK_LEN;
      ST_RED_POST: return CLEAR_LEN;
      default:     return GREEN_LEN;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_GREEN;
    else        state_q <= next_state;
  end

  // Every phase leaves on the tick that sees timer==1; green additionally needs a request,
  // and also leaves from 0 since it parks there when nobody is waiting.
  always_comb begin
    next_state = state_q;
    if (tick_1hz) begin
      case (state_q)
        ST_GREEN:    if (master_timer <= 7'd1 && req_pending) next_state = ST_YELLOW;
        ST_YELLOW:   if (master_timer == 7'd1) next_state = ST_RED_PRE;
        ST_RED_PRE:  if (master_timer == 7'd1) next_state = ST_WALK;
        ST_WALK:     if (master_timer == 7'd1) next_state = ST_RED_POST;
        ST_RED_POST: if (master_timer == 7'd1) next_state = ST_GREEN;
        default:     next_state = ST_GREEN;
      endcase
    end
  end

  always_comb begin
    timer_d = master_timer;
    if (tick_1hz) begin
      if (next_state != state_q)     timer_d = phase_len(next_state);
      else if (master_timer != 7'd0) timer_d = master_timer - 7'd1;
    end
  end

  // Clearing on walk entry takes priority over a button edge landing in the same clk.
  assign enter_walk = (next_state == ST_WALK) && (state_q != ST_WALK);

  always_comb begin
    req_d = req_pending;
    if (enter_walk)                             req_d = 1'b0;
    else if (btn_rise && (state_q != ST_WALK))  req_d = 1'b1;
  end

  always_comb begin
    lamps_d = lamp_decode(next_state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master_timer <= GREEN_LEN;
      req_pending  <= 1'b0;
      car_green    <= 1'b1;
      car_yellow   <= 1'b0;
      car_red      <= 1'b0;
      ped_enable   <= 1'b0;
    end else begin
      master_timer <= timer_d;
      req_pending  <= req_d;
      car_green    <= lamps_d.green;
      car_yellow   <= lamps_d.yellow;
      car_red      <= lamps_d.red;
      ped_enable   <= lamps_d.ped;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_crosswalk_controller.sv
// Directed bench for crosswalk_controller: full phase sequences, request latching rules,
// the green-at-zero and same-cycle edge/tick cases, and asynchronous mid-phase reset.
module tb_crosswalk_controller;
  import crosswalk_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       ped_button = 1'b0;
  logic [6:0] master_timer;
  logic       ped_enable;
  logic       car_green;
  logic       car_yellow;
  logic       car_red;
  logic       req_pending;
  logic [2:0] fsm_state;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  crosswalk_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .ped_button   (ped_button),
    .master_timer (master_timer),
    .ped_enable   (ped_enable),
    .car_green    (car_green),
    .car_yellow   (car_yellow),
    .car_red      (car_red),
    .req_pending  (req_pending),
    .fsm_state    (fsm_state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic expect_state(input string tag, input int t, input logic [2:0] st);
    int is_red;
    is_red = (st == ST_RED_PRE || st == ST_WALK || st == ST_RED_POST) ? 1 : 0;
    check({tag, ":timer"},  int'(master_timer), t);
    check({tag, ":state"},  int'(fsm_state),    int'(st));
    check({tag, ":green"},  int'(car_green),    (st == ST_GREEN)  ? 1 : 0);
    check({tag, ":yellow"}, int'(car_yellow),   (st == ST_YELLOW) ? 1 : 0);
    check({tag, ":red"},    int'(car_red),      is_red);
    check({tag, ":ped"},    int'(ped_enable),   (st == ST_WALK)   ? 1 : 0);
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) ped_button = 1'b1;
    repeat (5) @(negedge clk);
    ped_button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_state(tag, 20, ST_GREEN);
    check({tag, ":req"}, int'(req_pending), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs a phase just entered with timer=len down to its exit tick; optionally presses
  // the button while the timer shows press_at and checks the request latch afterwards.
  task automatic run_phase(input string tag, input int len, input logic [2:0] st,
                           input int press_at, input int req_after);
    expect_state(tag, len, st);
    for (int t = len; t >= 1; t--) begin
      if (t == press_at) begin
        press();
        check({tag, ":req_after_press"}, int'(req_pending), req_after);
      end
      pulse_tick();
      if (t > 1) expect_state(tag, t - 1, st);
    end
  endtask

  initial begin
    do_reset();
    expect_state("reset", 20, ST_GREEN);
    check("reset:req", int'(req_pending), 0);

    // No button: green counts 20..0 and parks at 0.
    for (int i = 1; i <= 40; i++) begin
      pulse_tick();
      expect_state("idle_green", (i < 20) ? 20 - i : 0, ST_GREEN);
      check("idle_green:req", int'(req_pending), 0);
    end

    // Press with green parked at 0: request visible on the 3rd clk, yellow on the next tick.
    @(negedge clk) ped_button = 1'b1;
    repeat (2) @(negedge clk);
    check("sync_latency:req_early", int'(req_pending), 0);
    @(negedge clk);
    check("sync_latency:req", int'(req_pending), 1);
    ped_button = 1'b0;
    repeat (4) @(negedge clk);
    expect_state("zero_green_wait", 0, ST_GREEN);
    pulse_tick();
    check("zero_green:req_in_yellow", int'(req_pending), 1);
    run_phase("c1_yellow", 4, ST_YELLOW, 0, 0);
    run_phase("c1_red_pre", 2, ST_RED_PRE, 0, 0);
    check("c1_walk_entry:req", int'(req_pending), 0);
    // Presses in walk are ignored.
    run_phase("c1_walk", 35, ST_WALK, 10, 0);
    run_phase("c1_red_post", 2, ST_RED_POST, 0, 0);
    expect_state("c1_back_green", 20, ST_GREEN);
    check("c1_back_green:req", int'(req_pending), 0);
    for (int i = 1; i <= 25; i++) begin
      pulse_tick();
      expect_state("c1_stay_green", (i < 20) ? 20 - i : 0, ST_GREEN);
    end

    // Request latched in RED_POST is held through a full 20-tick green.
    press();
    check("c2_press:req", int'(req_pending), 1);
    pulse_tick();
    run_phase("c2_yellow", 4, ST_YELLOW, 0, 0);
    run_phase("c2_red_pre", 2, ST_RED_PRE, 0, 0);
    run_phase("c2_walk", 35, ST_WALK, 0, 0);
    run_phase("c2_red_post", 2, ST_RED_POST, 2, 1);
    check("c2_green_entry:req", int'(req_pending), 1);
    run_phase("c2_green", 20, ST_GREEN, 0, 0);
    expect_state("c2_served", 4, ST_YELLOW);

    // Asynchronous reset mid-walk at timer 17.
    run_phase("c3_yellow", 4, ST_YELLOW, 0, 0);
    run_phase("c3_red_pre", 2, ST_RED_PRE, 0, 0);
    expect_state("c3_walk", 35, ST_WALK);
    for (int i = 1; i <= 18; i++) pulse_tick();
    expect_state("c3_walk17", 17, ST_WALK);
    async_reset_check("reset_in_walk");
    expect_state("after_reset_walk", 20, ST_GREEN);

    // Press at tick 5: yellow begins exactly on the 20th tick.
    for (int i = 1; i <= 5; i++) pulse_tick();
    press();
    check("c4_press:req", int'(req_pending), 1);
    for (int i = 6; i <= 19; i++) pulse_tick();
    expect_state("c4_green_last", 1, ST_GREEN);
    pulse_tick();
    expect_state("c4_yellow", 4, ST_YELLOW);
    check("c4_yellow:req", int'(req_pending), 1);

    // Reset during yellow discards the still-latched request.
    async_reset_check("reset_in_yellow");

    // Button edge coincides with a tick: that tick cannot start yellow.
    for (int i = 1; i <= 20; i++) pulse_tick();
    expect_state("c5_parked", 0, ST_GREEN);
    @(negedge clk) ped_button = 1'b1;
    repeat (2) @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    expect_state("c5_same_cycle", 0, ST_GREEN);
    check("c5_same_cycle:req", int'(req_pending), 1);
    ped_button = 1'b0;
    repeat (3) @(negedge clk);
    pulse_tick();
    expect_state("c5_next_tick", 4, ST_YELLOW);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
